neuron_driver: RTL

Operand sequencer that feeds the CORDIC neuron datapath and collects its activation result. It buffers an input/weight vector from an upstream valid/ready stream, replays it into the neuron one pair per CORDIC pass, and then enables the activation stage. It waits for the neuron's completion flag and returns the activation value on a downstream valid/ready port. This block is the initiator side of the neuron's operand/complete interface and sits between the layer memory and the neuron.

---
 rtl/neuron_driver_pkg.sv | 20 ++
 rtl/neuron_vec_buf.sv | 36 +++
 rtl/neuron_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_driver_pkg.sv
// Shared types and constants for the neuron operand sequencer.
// Holds the FSM state encoding, activation-select codes and the Q5.10 unit value.
package neuron_driver_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFill = 3'd1,
    StClr  = 3'd2,
    StMac  = 3'd3,
    StAct  = 3'd4,
    StHold = 3'd5
  } state_e;

  localparam logic [1:0] ActSig  = 2'b00;
  localparam logic [1:0] ActTanh = 2'b01;
  localparam logic [1:0] ActRelu = 2'b10;

  localparam logic [15:0] QOne = 16'h0400;

endpackage

// File: rtl/neuron_vec_buf.sv
// N_MAX-entry input/weight register file: one write port, combinational read.
module neuron_vec_buf #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned N_MAX = 8,
  parameter int unsigned AW    = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [WIDTH:0] wx_i,
  input  logic [WIDTH:0] ww_i,
  input  logic [AW-1:0]  raddr_i,
  output logic [WIDTH:0] rx_o,
  output logic [WIDTH:0] rw_o
);

  logic [WIDTH:0] x_q [N_MAX];
  logic [WIDTH:0] w_q [N_MAX];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_MAX; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (we_i) begin
      x_q[waddr_i] <= wx_i;
      w_q[waddr_i] <= ww_i;
    end
  end

  assign rx_o = x_q[raddr_i];
  assign rw_o = w_q[raddr_i];

endmodule

// File: rtl/neuron_driver.sv
// Operand sequencer for the CORDIC neuron: buffers a vector, replays it one pair
// per CORDIC pass, runs the activation stage and returns the result downstream.
module neuron_driver
  import neuron_driver_pkg::*;
#(
  parameter int unsigned WIDTH   = 15,
  parameter int unsigned N_MAX   = 8,
  parameter int unsigned ITERS   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           ext_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] in_x,
  input  logic [WIDTH:0] in_w,
  input  logic           in_last,
  input  logic [WIDTH:0] bias,
  input  logic [1:0]     act_sel,
  output logic [WIDTH:0] nrn_x,
  output logic [WIDTH:0] nrn_y,
  output logic [WIDTH:0] nrn_z,
  output logic           nrn_rst,
  output logic [1:0]     nrn_sel,
  output logic           nrn_af_en,
  input  logic           nrn_complete,
  input  logic [WIDTH:0] nrn_f,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] out_data,
  output logic           out_err
);

  localparam int unsigned CW = $clog2(N_MAX + 1);
  localparam int unsigned AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int unsigned IW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;
  logic [WIDTH:0] bias_q, bias_d;
  logic [1:0]     sel_q, sel_d;
  logic [WIDTH:0] data_q, data_d;
  logic           en_q;
  logic [WIDTH:0] buf_x, buf_w;
  logic           accept;

  assign accept = in_valid & in_ready;

  neuron_vec_buf #(
    .WIDTH (WIDTH),
    .N_MAX (N_MAX),
    .AW    (AW)
  ) u_vec_buf (
    .clk_i   (clk),
    .rst_ni  (ext_reset),
    .we_i    (accept),
    .waddr_i (count_q[AW-1:0]),
    .wx_i    (in_x),
    .ww_i    (in_w),
    .raddr_i (idx_q),
    .rx_o    (buf_x),
    .rw_o    (buf_w)
  );

  // en_q keeps in_ready low while reset is held and for the first cycle after release.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      bias_q  <= '0;
      sel_q   <= ActSig;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      bias_q  <= bias_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    timer_d = timer_q;
    err_d   = err_q;
    bias_d  = bias_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if (state_q == StIdle) begin
            bias_d  = bias;
            sel_d   = act_sel;
            state_d = StFill;
          end
          if (in_last) begin
            state_d = StClr;
            idx_d   = '0;
          end else if (count_q == CW'(N_MAX - 1)) begin
            // Buffer full without a last marker: truncate and flag.
            state_d = StClr;
            idx_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      StClr: begin
        idx_d   = '0;
        iter_d  = '0;
        state_d = StMac;
      end
      StMac: begin
        if (iter_q == IW'(ITERS - 1)) begin
          iter_d = '0;
          if (CW'(idx_q) + CW'(1) == count_q) begin
            timer_d = '0;
            state_d = StAct;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          iter_d = iter_q + IW'(1);
        end
      end
      StAct: begin
        // Completion takes priority over a coincident timeout.
        if (nrn_complete) begin
          data_d  = nrn_f;
          state_d = StHold;
        end else if (timer_q == TW'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    nrn_x     = '0;
    nrn_y     = '0;
    nrn_z     = '0;
    nrn_rst   = 1'b0;
    nrn_af_en = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle, StFill: in_ready = en_q && (count_q < CW'(N_MAX));
      StClr, StMac, StAct, StHold: begin
        nrn_x     = buf_x;
        nrn_z     = buf_w;
        nrn_y     = bias_q;
        nrn_rst   = (state_q == StClr);
        nrn_af_en = (state_q == StAct);
        out_valid = (state_q == StHold);
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign nrn_sel  = sel_q;
  assign out_data = data_q;
  assign out_err  = err_q & (state_q == StHold);

endmodule
